// File: rtl/sdp_bram_fifo_pkg.sv
// ============================================================================
// sdp_bram_fifo_pkg : shared constants and helpers for the SDP block-RAM FIFO
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package sdp_bram_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) w = i + 1;
        end
        return w;
    endfunction

    // One extra bit beyond the address is the wrap bit.
    function automatic int ptr_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdp_bram_fifo_if.sv
// ============================================================================
// sdp_bram_fifo_if : producer/consumer handshake bundle of the FIFO
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdp_bram_fifo_if #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_CNT_WIDTH  = 10
);
    logic                    flush;
    logic                    wr_en;
    logic [C_DATA_WIDTH-1:0] datain;
    logic                    full;
    logic                    almost_full;
    logic                    rd_en;
    logic [C_DATA_WIDTH-1:0] dataout;
    logic                    valid;
    logic                    empty;
    logic                    almost_empty;
    logic [C_CNT_WIDTH-1:0]  count;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output flush, wr_en, datain, rd_en,
        input  full, almost_full, dataout, valid, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, datain, rd_en,
        output full, almost_full, dataout, valid, empty, almost_empty,
               count, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/sdp_bram_core.sv
// ============================================================================
// sdp_bram_core : simple-dual-port RAM, 1-cycle registered read
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_bram_core #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_ADDR_WIDTH = 9
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [C_ADDR_WIDTH-1:0] wr_addr,
    input  logic [C_DATA_WIDTH-1:0] din,
    input  logic                    rd_en,
    input  logic [C_ADDR_WIDTH-1:0] rd_addr,
    output logic [C_DATA_WIDTH-1:0] dout
);
    logic [C_DATA_WIDTH-1:0] r_mem [0:(1 << C_ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= din;
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       dout <= '0;
        else if (rd_en) dout <= r_mem[rd_addr];
    end
endmodule

`default_nettype wire

// File: rtl/sdp_bram_fifo.sv
// ============================================================================
// sdp_bram_fifo : synchronous FIFO on one SDP block RAM, optional FWFT mode
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_bram_fifo
    import sdp_bram_fifo_pkg::*;
#(
    parameter int C_DATA_WIDTH    = 64,
    parameter int C_DEPTH         = 512,
    parameter int C_FWFT          = 0,
    parameter int C_AFULL_THRESH  = C_DEPTH - 4,
    parameter int C_AEMPTY_THRESH = 4
)(
    input  logic           clk,
    input  logic           rst,
    sdp_bram_fifo_if.slave bus
);
    localparam int            AW         = clog2(C_DEPTH);
    localparam int            PW         = ptr_width(C_DEPTH);
    localparam logic [PW-1:0] C_FULL_CNT = PW'(C_DEPTH);
    localparam logic [PW-1:0] C_AF_CNT   = PW'(C_AFULL_THRESH);
    localparam logic [PW-1:0] C_AE_CNT   = PW'(C_AEMPTY_THRESH);
    localparam bit            C_IS_FWFT  = (C_FWFT == int'(FIFO_FWFT));

    logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_count;
    logic          r_valid, r_full, r_afull, r_empty, r_aempty, r_ovf, r_udf;

    logic [PW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
    logic          w_valid_nxt, w_empty_nxt, w_ovf_nxt, w_udf_nxt;
    logic          w_wr_ok, w_rd_ok, w_fetch, w_storage_empty;

    always_comb begin
        w_storage_empty = (r_wr_ptr == r_rd_ptr);
        w_wr_ok         = bus.wr_en && !r_full  && !bus.flush;
        w_rd_ok         = bus.rd_en && !r_empty && !bus.flush;

        // FWFT prefetches whenever the output register is free or being popped.
        w_fetch = w_rd_ok;
        if (C_IS_FWFT)
            w_fetch = !bus.flush && !w_storage_empty && (!r_valid || bus.rd_en);

        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + PW'(1);
            2'b01:   w_count_nxt = r_count - PW'(1);
            default: w_count_nxt = r_count;
        endcase

        w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_ok);
        w_rd_ptr_nxt = r_rd_ptr + PW'(w_fetch);
        w_valid_nxt  = C_IS_FWFT ? (w_fetch || (r_valid && !w_rd_ok)) : w_rd_ok;
        w_ovf_nxt    = r_ovf || (bus.wr_en && r_full);
        w_udf_nxt    = r_udf || (bus.rd_en && r_empty);

        if (bus.flush) begin
            w_count_nxt  = '0;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_valid_nxt  = 1'b0;
            w_ovf_nxt    = 1'b0;
            w_udf_nxt    = 1'b0;
        end

        w_empty_nxt = C_IS_FWFT ? !w_valid_nxt : (w_count_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_valid  <= w_valid_nxt;
            r_full   <= (w_count_nxt == C_FULL_CNT);
            r_afull  <= (w_count_nxt >= C_AF_CNT);
            r_empty  <= w_empty_nxt;
            r_aempty <= (w_count_nxt <= C_AE_CNT);
            r_ovf    <= w_ovf_nxt;
            r_udf    <= w_udf_nxt;
        end
    end

    // In both modes the RAM output register is the data output register.
    sdp_bram_core #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_ADDR_WIDTH (AW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_ok),
        .wr_addr (r_wr_ptr[AW-1:0]),
        .din     (bus.datain),
        .rd_en   (w_fetch),
        .rd_addr (r_rd_ptr[AW-1:0]),
        .dout    (bus.dataout)
    );

    assign bus.full         = r_full;
    assign bus.almost_full  = r_afull;
    assign bus.valid        = r_valid;
    assign bus.empty        = r_empty;
    assign bus.almost_empty = r_aempty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;
endmodule

`default_nettype wire
